// File: rtl/conv_check_5d_if.sv
// Bus between the convergence checker and its neighbours: the normalised
// vector handshake, the per-component clear, and the evaluation results.
interface conv_check_5d_if #(
  parameter int unsigned DIMENSIONS = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned ITER_WIDTH = 8
);
  logic                               clear;
  logic [DIMENSIONS*DATA_WIDTH-1:0]   w_new;
  logic                               w_new_vld;
  logic                               busy;
  logic                               done;
  logic                               converged;
  logic                               timeout;
  logic [ITER_WIDTH-1:0]              iter_count;
  logic [ACC_WIDTH-1:0]               dot_abs;
  logic [DIMENSIONS*DATA_WIDTH-1:0]   w_prev;

  // Upstream side: supplies vectors and clear, observes results.
  modport master (
    output clear, w_new, w_new_vld,
    input  busy, done, converged, timeout, iter_count, dot_abs, w_prev
  );

  // Checker side.
  modport slave (
    input  clear, w_new, w_new_vld,
    output busy, done, converged, timeout, iter_count, dot_abs, w_prev
  );
endinterface

// File: rtl/conv_check_5d.sv
// FastICA convergence checker: sequential MAC of w_new . w_prev, then
// compares |dot| against 1.0 within TOL and tracks the iteration count.
module conv_check_5d #(
  parameter int unsigned DIMENSIONS = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter logic [31:0] TOL        = 32'h0000_0020,
  parameter int unsigned MAX_ITER   = 64,
  parameter int unsigned ITER_WIDTH = 8
) (
  input logic           clk,
  input logic           nreset,
  conv_check_5d_if.slave bus
);

  localparam int unsigned IdxW = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;
  localparam logic signed [ACC_WIDTH-1:0] One = ACC_WIDTH'(1) << FRAC_BITS;

  typedef enum logic [1:0] {StIdle, StMac, StCmp, StDone} state_e;

  state_e                            state;
  logic [DIMENSIONS*DATA_WIDTH-1:0]  w_cur;
  logic [DIMENSIONS*DATA_WIDTH-1:0]  w_prev_q;
  logic                              prev_vld;
  logic signed [ACC_WIDTH-1:0]       acc;
  logic [IdxW-1:0]                   idx;
  logic                              converged_q;
  logic                              timeout_q;
  logic [ITER_WIDTH-1:0]             iter_q;
  logic [ACC_WIDTH-1:0]              dot_q;

  logic signed [DATA_WIDTH-1:0]      cur_elem;
  logic signed [DATA_WIDTH-1:0]      prev_elem;
  logic signed [2*DATA_WIDTH-1:0]    prod;
  logic signed [ACC_WIDTH-1:0]       term;
  logic [ACC_WIDTH-1:0]              acc_abs;
  logic signed [ACC_WIDTH-1:0]       diff;
  logic [ACC_WIDTH-1:0]              diff_abs;
  logic                              conv_hit;
  logic [ITER_WIDTH-1:0]             iter_inc;

  // MAC term for the current element and the compare against 1.0.
  always_comb begin
    cur_elem  = $signed(w_cur[idx*DATA_WIDTH +: DATA_WIDTH]);
    prev_elem = $signed(w_prev_q[idx*DATA_WIDTH +: DATA_WIDTH]);
    prod      = cur_elem * prev_elem;
    term      = ACC_WIDTH'(prod >>> FRAC_BITS);
    acc_abs   = acc[ACC_WIDTH-1] ? -acc : acc;
    diff      = One - $signed(acc_abs);
    diff_abs  = diff[ACC_WIDTH-1] ? -diff : diff;
    conv_hit  = prev_vld && (diff_abs <= ACC_WIDTH'(TOL));
    iter_inc  = (iter_q == ITER_WIDTH'(MAX_ITER)) ? iter_q : iter_q + 1'b1;
  end

  // Control FSM and all result registers; clear outranks a new vector.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= StIdle;
      w_cur       <= '0;
      w_prev_q    <= '0;
      prev_vld    <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
      iter_q      <= '0;
      dot_q       <= '0;
    end else if (bus.clear) begin
      state       <= StIdle;
      w_prev_q    <= '0;
      prev_vld    <= 1'b0;
      converged_q <= 1'b0;
      timeout_q   <= 1'b0;
      iter_q      <= '0;
      dot_q       <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.w_new_vld) begin
            w_cur <= bus.w_new;
            acc   <= '0;
            idx   <= '0;
            state <= StMac;
          end
        end
        StMac: begin
          acc <= acc + term;
          idx <= idx + 1'b1;
          if (idx == IdxW'(DIMENSIONS - 1)) state <= StCmp;
        end
        StCmp: begin
          // The first vector after clear has no partner: report a zero dot.
          dot_q       <= prev_vld ? acc_abs : '0;
          converged_q <= conv_hit;
          iter_q      <= iter_inc;
          timeout_q   <= (iter_inc == ITER_WIDTH'(MAX_ITER)) && !conv_hit;
          w_prev_q    <= w_cur;
          prev_vld    <= 1'b1;
          state       <= StDone;
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy       = (state != StIdle);
  assign bus.done       = (state == StDone);
  assign bus.converged  = converged_q;
  assign bus.timeout    = timeout_q;
  assign bus.iter_count = iter_q;
  assign bus.dot_abs    = dot_q;
  assign bus.w_prev     = w_prev_q;

endmodule

// File: tb/tb_conv_check_5d.sv
// Bench for conv_check_5d with MAX_ITER=4: table of vectors with expected
// results, scoreboard queue popped on done, plus clear/reset sequences.
module tb_conv_check_5d;

  localparam int unsigned W = 5 * 32;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  conv_check_5d_if bus ();

  conv_check_5d #(.MAX_ITER(4)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  typedef struct {
    logic         clr;
    logic [W-1:0] w;
    logic         conv;
    logic [39:0]  dot;
    logic [7:0]   iter;
    logic         to;
  } vec_t;

  typedef struct {
    logic         conv;
    logic [39:0]  dot;
    logic [7:0]   iter;
    logic         to;
    logic [W-1:0] w;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[12];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] mk(input logic [31:0] e0, input logic [31:0] e1,
                                      input logic [31:0] e2, input logic [31:0] e3,
                                      input logic [31:0] e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // Drive one vector, push its expectation, wait (bounded) for done, compare.
  task automatic run_vec(input logic [W-1:0] w, input exp_t e);
    int   n;
    exp_t got;
    sbq.push_back(e);
    @(negedge clk);
    bus.w_new     = w;
    bus.w_new_vld = 1'b1;
    @(negedge clk);
    bus.w_new_vld = 1'b0;
    chk("busy_after_accept", W'(bus.busy), W'(1));
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_wait actual=no_done required=done");
      void'(sbq.pop_front());
    end else begin
      got = sbq.pop_front();
      chk("latency", W'(n), W'(6));
      chk("converged", W'(bus.converged), W'(got.conv));
      chk("dot_abs", W'(bus.dot_abs), W'(got.dot));
      chk("iter_count", W'(bus.iter_count), W'(got.iter));
      chk("timeout", W'(bus.timeout), W'(got.to));
      chk("w_prev", bus.w_prev, got.w);
      @(negedge clk);
      chk("done_one_cycle", W'(bus.done), W'(0));
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, W'(bus.busy), W'(0));
    chk({tag, "_done"}, W'(bus.done), W'(0));
    chk({tag, "_conv"}, W'(bus.converged), W'(0));
    chk({tag, "_timeout"}, W'(bus.timeout), W'(0));
    chk({tag, "_iter"}, W'(bus.iter_count), W'(0));
    chk({tag, "_dot"}, W'(bus.dot_abs), W'(0));
    chk({tag, "_wprev"}, bus.w_prev, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    exp_t         ex;
    int           seen;

    e1 = mk(32'h0001_0000, 0, 0, 0, 0);
    e2 = mk(0, 32'h0001_0000, 0, 0, 0);

    // clr, vector, converged, dot_abs, iter_count, timeout
    tbl[0]  = '{1'b1, e1, 1'b0, 40'h0, 8'd1, 1'b0};
    tbl[1]  = '{1'b0, e1, 1'b1, 40'h10000, 8'd2, 1'b0};
    tbl[2]  = '{1'b0, mk(32'hFFFF_0000, 0, 0, 0, 0), 1'b1, 40'h10000, 8'd3, 1'b0};
    tbl[3]  = '{1'b0, e2, 1'b0, 40'h0, 8'd4, 1'b1};
    tbl[4]  = '{1'b0, e1, 1'b0, 40'h0, 8'd4, 1'b1};
    tbl[5]  = '{1'b1, e1, 1'b0, 40'h0, 8'd1, 1'b0};
    tbl[6]  = '{1'b0, mk(32'h0000_FFE0, 0, 0, 0, 0), 1'b1, 40'hFFE0, 8'd2, 1'b0};
    tbl[7]  = '{1'b1, e1, 1'b0, 40'h0, 8'd1, 1'b0};
    tbl[8]  = '{1'b0, mk(32'h0000_FFDF, 0, 0, 0, 0), 1'b0, 40'hFFDF, 8'd2, 1'b0};
    tbl[9]  = '{1'b0, mk(32'h8000, 32'h8000, 32'h8000, 32'h8000, 0),
                1'b0, 40'h7FEF, 8'd3, 1'b0};
    tbl[10] = '{1'b0, mk(32'h8000, 32'h8000, 32'h8000, 32'h8000, 0),
                1'b1, 40'h10000, 8'd4, 1'b0};
    tbl[11] = '{1'b0, mk(32'h8000, 32'hFFFF_8000, 32'h8000, 32'hFFFF_8000, 0),
                1'b0, 40'h0, 8'd4, 1'b1};

    bus.clear     = 1'b0;
    bus.w_new     = '0;
    bus.w_new_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    nreset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].clr) pulse_clear();
      ex = '{tbl[i].conv, tbl[i].dot, tbl[i].iter, tbl[i].to, tbl[i].w};
      run_vec(tbl[i].w, ex);
    end

    // Clear mid-MAC: no done, everything back to zero.
    @(negedge clk);
    bus.w_new     = e1;
    bus.w_new_vld = 1'b1;
    @(negedge clk);
    bus.w_new_vld = 1'b0;
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk_cleared("clear_mac");
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("clear_mac_no_done", W'(seen), W'(0));

    // Vector and clear together: vector dropped.
    @(negedge clk);
    bus.w_new     = e2;
    bus.w_new_vld = 1'b1;
    bus.clear     = 1'b1;
    @(negedge clk);
    bus.w_new_vld = 1'b0;
    bus.clear     = 1'b0;
    chk("vld_clear_busy", W'(bus.busy), W'(0));
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("vld_clear_idle", W'(seen), W'(0));

    // Next vector treated as the first of a new component.
    ex = '{1'b0, 40'h0, 8'd1, 1'b0, e1};
    run_vec(e1, ex);

    // Asynchronous reset mid-evaluation.
    @(negedge clk);
    bus.w_new     = e1;
    bus.w_new_vld = 1'b1;
    @(negedge clk);
    bus.w_new_vld = 1'b0;
    @(negedge clk);
    #1 nreset = 1'b0;
    #1 chk_cleared("async_reset");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("reset_idle", W'(bus.busy), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
